// File: rtl/precision_vector_pkg.sv
// Shared types for the lane-folded vector add/subtract engine.
package precision_vector_pkg;

  typedef enum logic [1:0] {
    OP_SUB  = 2'd0,
    OP_ADD  = 2'd1,
    OP_RSUB = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The sign lives in the MSB for every IEEE format, so one helper covers all widths.
  function automatic logic [63:0] flip_sign(input logic [63:0] v, input int bits);
    return v ^ (64'd1 << (bits - 1));
  endfunction

endpackage

// File: rtl/addsub_lane.sv
// One lane: maps op onto a plain subtractor by swapping or negating operands.
module addsub_lane
  import precision_vector_pkg::*;
#(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF"
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  op_t             op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  output logic [BITS-1:0] c
);
  logic [BITS-1:0] x, y;

  // SUB/RSVD pass through, ADD negates b, RSUB swaps the operands.
  always_comb begin
    x = a;
    y = b;
    case (op)
      OP_ADD:  y = BITS'(flip_sign(64'(b), BITS));
      OP_RSUB: begin x = b; y = a; end
      default: ;
    endcase
  end

  subtract #(.BITS(BITS), .PRECISION(PRECISION)) u_sub (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .a         (x),
    .b         (y),
    .out_valid (out_valid),
    .c         (c)
  );

endmodule

// File: rtl/subtract.sv
// Pipelined IEEE-754 subtractor c = a - b, round-to-nearest-even, latency 2.
module subtract #(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF"
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  output logic [BITS-1:0] c
);
  localparam int EW = (PRECISION == "DOUBLE") ? 11 : (PRECISION == "SINGLE") ? 8 : 5;
  localparam int MW = BITS - 1 - EW;
  localparam int W  = MW + 4;  // hidden bit + fraction + guard/round/sticky
  localparam logic [EW-1:0]   EMAX = '1;
  localparam logic [BITS-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

  logic [1:0]      vld_pipe;
  logic [BITS-1:0] ra, rb, res;
  logic            sa, sb, sx, sy, sr, sticky, rnd;
  logic [EW-1:0]   ea, eb;
  logic [EW+1:0]   ex, ey, er;
  logic [MW:0]     ma, mb, mx, my;
  logic [W-1:0]    ax, ay, n;
  logic [W:0]      s;
  logic [BITS-2:0] mag;
  int              d, msb, sh;

  // Valid shift register; cleared by reset so nothing in flight survives it.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[0], in_valid};

  // Operand capture and result register; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    ra <= a;
    rb <= b;
    c  <= res;
  end

  assign out_valid = vld_pipe[1];

  // a + (-b): swap to larger magnitude, align, add/sub, normalise, round.
  always_comb begin
    sa = ra[BITS-1];
    sb = ~rb[BITS-1];
    ea = ra[BITS-2:MW];
    eb = rb[BITS-2:MW];
    ma = {|ea, ra[MW-1:0]};
    mb = {|eb, rb[MW-1:0]};
    if (ra[BITS-2:0] >= rb[BITS-2:0]) begin
      sx = sa; sy = sb; mx = ma; my = mb;
      ex = (ea == '0) ? (EW+2)'(1) : {2'b00, ea};
      ey = (eb == '0) ? (EW+2)'(1) : {2'b00, eb};
    end else begin
      sx = sb; sy = sa; mx = mb; my = ma;
      ex = (eb == '0) ? (EW+2)'(1) : {2'b00, eb};
      ey = (ea == '0) ? (EW+2)'(1) : {2'b00, ea};
    end
    d  = int'(ex) - int'(ey);
    ax = {mx, 3'b000};
    ay = {my, 3'b000};
    sticky = 1'b0;
    for (int i = 0; i < W; i++)
      if (i < d && ay[i]) sticky = 1'b1;
    ay    = (d >= W) ? '0 : (ay >> d);
    ay[0] = ay[0] | sticky;
    s = (sx == sy) ? ({1'b0, ax} + {1'b0, ay}) : ({1'b0, ax} - {1'b0, ay});
    msb = 0;
    for (int i = 0; i <= W; i++)
      if (s[i]) msb = i;
    sh = 0;
    if (s[W]) begin
      n  = {s[W:2], s[1] | s[0]};
      er = ex + (EW+2)'(1);
    end else begin
      // Left shift is capped so tiny results land as subnormals (field 0).
      sh = W - 1 - msb;
      if (sh > int'(ex) - 1) sh = int'(ex) - 1;
      n  = s[W-1:0] << sh;
      er = n[W-1] ? ex - (EW+2)'(sh) : '0;
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    mag = {er[EW-1:0], n[W-2:3]} + {{(BITS-2){1'b0}}, rnd};
    if (er >= {2'b00, EMAX}) mag = {EMAX, {MW{1'b0}}};
    sr  = (s == '0 && sx != sy) ? 1'b0 : sx;
    res = {sr, mag};
    if (ea == EMAX || eb == EMAX) begin
      if ((ea == EMAX && ra[MW-1:0] != '0) || (eb == EMAX && rb[MW-1:0] != '0) ||
          (ea == EMAX && eb == EMAX && sa != sb))
        res = QNAN;
      else
        res = (ea == EMAX) ? {sa, EMAX, {MW{1'b0}}} : {sb, EMAX, {MW{1'b0}}};
    end
  end

endmodule

// File: rtl/addsub_vector_seq.sv
// N-element add/subtract folded onto LANES shared subtractors over BEATS beats.
module addsub_vector_seq
  import precision_vector_pkg::*;
#(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF",
  parameter int    N         = 8,
  parameter int    LANES     = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [N-1:0][BITS-1:0] a,
  input  logic [N-1:0][BITS-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0][BITS-1:0] c
);
  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                    state, state_n;
  logic [CW-1:0]             issue_beat, ret_beat;
  logic [N-1:0][BITS-1:0]    a_q, b_q;
  op_t                       op_q;
  logic [LANES-1:0][BITS-1:0] lane_a, lane_b, lane_c;
  logic [LANES-1:0]          lane_vld;
  logic                      accept, issue, collect, last_issue, last_ret;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign issue      = (state == ISSUE);
  // Lanes run in lockstep, so any lane's valid stands for the whole beat.
  assign collect    = (state == ISSUE || state == DRAIN) && (&lane_vld);
  assign last_issue = (issue_beat == CW'(BEATS - 1));
  assign last_ret   = (ret_beat == CW'(BEATS - 1));

  // Next-state: finishing the last write wins even while still issuing.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ISSUE;
      ISSUE:   if (collect && last_ret) state_n = DONE;
               else if (last_issue)     state_n = DRAIN;
      DRAIN:   if (collect && last_ret) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and beat counters.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= IDLE;
      issue_beat <= '0;
      ret_beat   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        issue_beat <= '0;
        ret_beat   <= '0;
      end else begin
        if (issue && !last_issue) issue_beat <= issue_beat + CW'(1);
        if (collect)              ret_beat   <= ret_beat + CW'(1);
      end
    end

  // Operands are captured once at accept and held for the whole run.
  always_ff @(posedge clk)
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_t'(op);
    end

  // Steer the current beat's elements onto lanes; pad lanes see zeros.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < N; i++)
      if (issue_beat == CW'(i / LANES)) begin
        lane_a[i % LANES] = a_q[i];
        lane_b[i % LANES] = b_q[i];
      end
  end

  // Result buffer: only real elements are written, pad results fall away.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) c <= '0;
    else if (collect)
      for (int i = 0; i < N; i++)
        if (ret_beat == CW'(i / LANES)) c[i] <= lane_c[i % LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    addsub_lane #(.BITS(BITS), .PRECISION(PRECISION)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (issue),
      .op        (op_q),
      .a         (lane_a[l]),
      .b         (lane_b[l]),
      .out_valid (lane_vld[l]),
      .c         (lane_c[l])
    );
  end

endmodule
